uart_cmd_ctrl: RTL and testbench

Byte-level command controller between uart_rx/uart_tx and a simple 8-bit register bus. Parses host frames from the receiver's data/valid stream, issues single-cycle register reads and writes, and sequences response bytes into the transmitter using its start/busy handshake. It is the sequencing layer above the UART datapath in the DDK host-control path.

---
 rtl/uart_cmd_ctrl_pkg.sv | 28 ++
 rtl/uart_cmd_ctrl.sv | 128 ++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_cmd_ctrl_pkg.sv
// Shared state encodings, protocol byte defaults and helpers for uart_cmd_ctrl.
// The optional write acknowledge is selected by the UART_CMD_ACK_EN macro.
package uart_cmd_ctrl_pkg;

    // Nine states do not fit in three bits, so four bits are used.
    localparam int STATE_W = 4;

    localparam logic [STATE_W-1:0] ST_IDLE     = 4'd0;
    localparam logic [STATE_W-1:0] ST_W_ADDR   = 4'd1;
    localparam logic [STATE_W-1:0] ST_W_DATA   = 4'd2;
    localparam logic [STATE_W-1:0] ST_EXEC_WR  = 4'd3;
    localparam logic [STATE_W-1:0] ST_R_ADDR   = 4'd4;
    localparam logic [STATE_W-1:0] ST_EXEC_RD  = 4'd5;
    localparam logic [STATE_W-1:0] ST_RD_CAP   = 4'd6;
    localparam logic [STATE_W-1:0] ST_TX_WAIT  = 4'd7;
    localparam logic [STATE_W-1:0] ST_TX_GUARD = 4'd8;

    localparam int          DEF_TIMEOUT_CYCLES = 100000;
    localparam logic [7:0]  DEF_OP_WRITE       = 8'h57;
    localparam logic [7:0]  DEF_OP_READ        = 8'h52;
    localparam logic [7:0]  DEF_ACK_BYTE       = 8'h06;

    // States that are waiting for the next byte of a frame and so run the timeout.
    function automatic logic in_frame(input logic [STATE_W-1:0] s);
        return (s == ST_W_ADDR) || (s == ST_W_DATA) || (s == ST_R_ADDR);
    endfunction

endpackage

// File: rtl/uart_cmd_ctrl.sv
// Byte-level host command controller: parses 'W' addr data / 'R' addr frames,
// drives a single-cycle register bus and returns read data via uart_tx.
// Define UART_CMD_ACK_EN to acknowledge each completed write with ACK_BYTE.
module uart_cmd_ctrl
    import uart_cmd_ctrl_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter logic [7:0] OP_WRITE       = DEF_OP_WRITE,
    parameter logic [7:0] OP_READ        = DEF_OP_READ
`ifdef UART_CMD_ACK_EN
    ,
    parameter logic [7:0] ACK_BYTE       = DEF_ACK_BYTE
`endif
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       err
);

    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [STATE_W-1:0] state;
    logic [CNT_W-1:0]   cnt;
    logic               timeout;
    logic               busy_state;

    assign timeout    = !rx_valid && (cnt == CNT_LAST);
    assign busy_state = (state != ST_IDLE) && !in_frame(state);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            tx_data   <= '0;
            tx_start  <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            reg_we    <= 1'b0;
            reg_re    <= 1'b0;
            err       <= 1'b0;
        end else begin
            // NOTE: strobes default low every cycle so each pulse is exactly one clock wide.
            tx_start <= 1'b0;
            reg_we   <= 1'b0;
            reg_re   <= 1'b0;
            err      <= 1'b0;

            if (rx_valid || !in_frame(state)) cnt <= '0;
            else                              cnt <= cnt + 1'b1;

            case (state)
                ST_IDLE: begin
                    if (rx_valid) begin
                        if (rx_data == OP_WRITE)     state <= ST_W_ADDR;
                        else if (rx_data == OP_READ) state <= ST_R_ADDR;
                        else                         err   <= 1'b1;
                    end
                end
                ST_W_ADDR: begin
                    if (rx_valid) begin
                        reg_addr <= rx_data;
                        state    <= ST_W_DATA;
                    end else if (timeout) begin
                        err   <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                ST_W_DATA: begin
                    // Strobe is registered on entry so it is high exactly while in EXEC_WR.
                    if (rx_valid) begin
                        reg_wdata <= rx_data;
                        reg_we    <= 1'b1;
                        state     <= ST_EXEC_WR;
                    end else if (timeout) begin
                        err   <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                ST_R_ADDR: begin
                    if (rx_valid) begin
                        reg_addr <= rx_data;
                        reg_re   <= 1'b1;
                        state    <= ST_EXEC_RD;
                    end else if (timeout) begin
                        err   <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                ST_EXEC_WR: begin
`ifdef UART_CMD_ACK_EN
                    tx_data <= ACK_BYTE;
                    state   <= ST_TX_WAIT;
`else
                    state   <= ST_IDLE;
`endif
                end
                ST_EXEC_RD: state <= ST_RD_CAP;
                ST_RD_CAP: begin
                    tx_data <= reg_rdata;
                    state   <= ST_TX_WAIT;
                end
                ST_TX_WAIT: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        state    <= ST_TX_GUARD;
                    end
                end
                ST_TX_GUARD: state <= ST_IDLE;
                default:     state <= ST_IDLE;
            endcase

            // Bytes arriving while a command executes or responds are dropped.
            if (rx_valid && busy_state) err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed plus randomized bench for uart_cmd_ctrl with a frame-level register model.
// Expectations follow UART_CMD_ACK_EN when the macro is defined for the build.
`timescale 1ns/1ps
module tb_uart_cmd_ctrl;

    localparam int         TIMEOUT = 16;
    localparam logic [7:0] OP_W    = 8'h57;
    localparam logic [7:0] OP_R    = 8'h52;
    localparam logic [7:0] ACK     = 8'h06;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata = '0;
    logic       err;

    always #5 clk = ~clk;

    uart_cmd_ctrl #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_re    (reg_re),
        .reg_rdata (reg_rdata),
        .err       (err)
    );

    // Register-bus slave and transmitter stand-in.
    logic [7:0] init_mem  [256];
    logic [7:0] slave_mem [256];
    logic [7:0] model_mem [256];
    logic       mem_loaded = 1'b0;
    int         busy_cnt = 0;
    logic       force_busy = 1'b0;

    assign tx_busy = (busy_cnt != 0) || force_busy;

    always @(posedge clk) begin
        if (rst && !mem_loaded) begin
            for (int i = 0; i < 256; i++) slave_mem[i] <= init_mem[i];
            mem_loaded <= 1'b1;
        end else if (reg_we) begin
            slave_mem[reg_addr] <= reg_wdata;
        end
        reg_rdata <= reg_re ? slave_mem[reg_addr] : 8'($urandom);
        if (rst)                busy_cnt <= 0;
        else if (tx_start)      busy_cnt <= 8;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    // Event monitor sampled on the inactive edge.
    int         cyc = 0;
    int         we_n = 0, re_n = 0, st_n = 0, err_n = 0, unstable = 0;
    int         we_cyc = 0, re_cyc = 0, st_cyc = 0, err_cyc = 0;
    logic [7:0] we_addr = '0, we_data = '0, re_addr = '0, st_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (reg_we)   begin we_n++; we_cyc = cyc; we_addr = reg_addr; we_data = reg_wdata; end
        if (reg_re)   begin re_n++; re_cyc = cyc; re_addr = reg_addr; end
        if (tx_start) begin st_n++; st_cyc = cyc; st_data = tx_data; end
        if (err)      begin err_n++; err_cyc = cyc; end
        if (busy_cnt != 0 && tx_data !== st_data) unstable++;
    end

    int n_checks = 0;
    int n_errors = 0;
    int last_edge = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data   = b;
        rx_valid  = 1'b1;
        last_edge = cyc + 1;
        @(negedge clk);
        rx_valid  = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [7:0] d, input int gap);
        int we0, err0, st0, data_edge;
        we0 = we_n; err0 = err_n; st0 = st_n;
        send_byte(OP_W); idle(gap);
        send_byte(a);    idle(gap);
        send_byte(d);    data_edge = last_edge;
        idle(14); #1;
        model_mem[a] = d;
        check("wr_count", we_n - we0, 1);
        check("wr_addr", we_addr, a);
        check("wr_data", we_data, d);
        check("wr_latency", we_cyc - data_edge, 0);
        check("wr_err", err_n - err0, 0);
`ifdef UART_CMD_ACK_EN
        check("wr_ack_count", st_n - st0, 1);
        check("wr_ack_byte", st_data, ACK);
`else
        check("wr_no_tx", st_n - st0, 0);
`endif
    endtask

    task automatic do_read(input logic [7:0] a, input int hold, input int gap);
        int re0, err0, st0, addr_edge, c_rel;
        re0 = re_n; err0 = err_n; st0 = st_n; c_rel = 0;
        if (hold > 0) force_busy = 1'b1;
        send_byte(OP_R); idle(gap);
        send_byte(a);    addr_edge = last_edge;
        if (hold > 0) begin
            idle(hold / 2);
            send_byte(8'hC3);
            idle(hold / 2);
            check("rd_withheld", st_n - st0, 0);
            check("rd_stray_err", err_n - err0, 1);
            c_rel = cyc;
            force_busy = 1'b0;
        end
        idle(14); #1;
        check("rd_count", re_n - re0, 1);
        check("rd_addr", re_addr, a);
        check("rd_strobe_cycle", re_cyc - addr_edge, 0);
        check("rd_tx_count", st_n - st0, 1);
        check("rd_tx_data", st_data, model_mem[a]);
        check("rd_min_latency", (st_cyc - addr_edge) >= 3, 1);
        if (hold > 0) check("rd_release", st_cyc - c_rel, 1);
        else          check("rd_err", err_n - err0, 0);
    endtask

    initial begin
        int err0, we0, re0, st0, e0;
        for (int i = 0; i < 256; i++) init_mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) model_mem[i] = init_mem[i];

        rst = 1'b1;
        idle(3); #1;
        check("reset_outputs", {tx_start, reg_we, reg_re, err, tx_data, reg_addr, reg_wdata}, 0);
        @(negedge clk); rst = 1'b0;

        // Basic write and read.
        do_write(8'h10, 8'hA5, 0);
        do_write(8'h3C, 8'h5A, 1);
        do_read(8'h3C, 0, 0);

        // Transmitter busy for 50 cycles with a stray byte meanwhile.
        do_read(8'h10, 50, 2);

        // Unknown opcode, then a normal read.
        err0 = err_n; we0 = we_n; re0 = re_n; st0 = st_n;
        send_byte(8'h41); idle(4); #1;
        check("badop_err", err_n - err0, 1);
        check("badop_strobes", (we_n - we0) + (re_n - re0) + (st_n - st0), 0);
        do_read(8'h00, 0, 1);

        // Timeout after a partial write frame.
        err0 = err_n; we0 = we_n;
        send_byte(OP_W); send_byte(8'h10); e0 = last_edge;
        idle(20); #1;
        check("to_err", err_n - err0, 1);
        check("to_err_cycle", err_cyc - e0, TIMEOUT);
        check("to_no_write", we_n - we0, 0);
        do_write(8'h10, 8'hA5, 0);

        // A byte landing on the terminal count is accepted without error.
        err0 = err_n; we0 = we_n;
        send_byte(OP_W); idle(TIMEOUT - 2);
        send_byte(8'h77); send_byte(8'h88);
        idle(14); #1;
        model_mem[8'h77] = 8'h88;
        check("tc_no_err", err_n - err0, 0);
        check("tc_write", we_n - we0, 1);
        check("tc_addr", we_addr, 8'h77);

        // Reset in the middle of a frame.
        we0 = we_n;
        send_byte(OP_W); send_byte(8'h10);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        idle(5); #1;
        check("rst_no_write", we_n - we0, 0);
        check("rst_addr_clear", reg_addr, 0);
        do_write(8'h20, 8'h01, 0);

        // Top of the address and data range.
        do_write(8'hFF, 8'hFF, 0);
        do_read(8'hFF, 0, 0);

        // Randomized mix of frames.
        for (int k = 0; k < 24; k++) begin
            logic [7:0] a, d;
            a = 8'($urandom);
            d = 8'($urandom);
            if ($urandom_range(0, 1) == 1) do_write(a, d, $urandom_range(0, 5));
            else                           do_read(a, 0, $urandom_range(0, 5));
        end

        check("tx_data_stable", unstable, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
